// File: rtl/adc_ad7476_pkg.sv
// Shared types and constants for the AD7476 capture front end.
// Frame layout: 4 leading zeros followed by a 12-bit conversion result, MSB first.
package adc_ad7476_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        PUSH_LO,
        PUSH_HI,
        QUIET
    } state_t;

    localparam int FRAME_BITS = 16;
    localparam int LEAD_ZEROS = 4;
    localparam int DATA_BITS  = 12;

    // One full frame of SCLK plus the quiet time and the push/return overhead.
    function automatic int min_sample_period(input int sclk_div, input int cs_quiet);
        return 2 * FRAME_BITS * sclk_div + cs_quiet + 3;
    endfunction

endpackage

// File: rtl/adc_ad7476_sclk_gen.sv
// SCLK generator for one AD7476 frame: half-period divider plus rising-edge counter.
// SCLK idles high and runs only while 'run' is asserted.
module adc_ad7476_sclk_gen
    import adc_ad7476_pkg::*;
#(
    parameter int SCLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic sclk,
    output logic rise_strobe,
    output logic frame_done
);

    localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);
    localparam int RW = $clog2(FRAME_BITS + 1);
    localparam logic [RW-1:0] RISE_LAST = RW'(FRAME_BITS);

    logic [DW-1:0] div_cnt;
    logic [RW-1:0] rise_cnt;

    assign frame_done  = run && (rise_cnt == RISE_LAST);
    // Asserted in the cycle whose closing edge drives SCLK high.
    assign rise_strobe = run && (div_cnt == DIV_LAST) && !sclk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt  <= '0;
            sclk     <= 1'b1;
            rise_cnt <= '0;
        end else if (!run) begin
            div_cnt  <= '0;
            sclk     <= 1'b1;
            rise_cnt <= '0;
        end else if (!frame_done) begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                sclk    <= ~sclk;
                if (!sclk) begin
                    rise_cnt <= rise_cnt + 1'b1;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_ad7476_capture.sv
// AD7476 capture: paces conversions, shifts in 16-bit frames and pushes the
// 12-bit result into the sample FIFO as two bytes, low byte first.
module adc_ad7476_capture
    import adc_ad7476_pkg::*;
#(
    parameter int SCLK_DIV      = 2,
    parameter int SAMPLE_PERIOD = 1000,
    parameter int CS_QUIET      = 4,
    parameter int CNT_W         = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Enable,
    input  logic             ADC_SDATA,
    output logic             ADC_SCLK,
    output logic             ADC_CSn,
    input  logic             Almost_Full,
    output logic             Fifo_Push,
    output logic [7:0]       Fifo_Din,
    output logic             Busy,
    output logic             Overrun,
    output logic             Frame_Err,
    input  logic             Err_Clr,
    output logic [CNT_W-1:0] Sample_Count
);

    localparam int PW = $clog2(SAMPLE_PERIOD + 1);
    localparam logic [PW-1:0] PERIOD_LOAD = PW'(SAMPLE_PERIOD - 1);
    localparam int QW = $clog2(CS_QUIET + 1) + 1;
    localparam logic [QW-1:0] QUIET_MAX  = QW'(CS_QUIET);
    localparam logic [QW-1:0] QUIET_EXIT = QW'((CS_QUIET > 1) ? CS_QUIET - 1 : 0);

    generate
        if (SCLK_DIV < 1 || SAMPLE_PERIOD < min_sample_period(SCLK_DIV, CS_QUIET)) begin : g_bad_params
            $error("adc_ad7476_capture: SAMPLE_PERIOD too short for SCLK_DIV/CS_QUIET");
        end
    endgenerate

    state_t                state;
    logic [PW-1:0]         period_cnt;
    logic [QW-1:0]         quiet_cnt;
    logic [FRAME_BITS-1:0] frame;
    logic                  run;
    logic                  sclk_rise;
    logic                  frame_done;
    logic                  start;
    logic                  lead_err;

    assign run      = (state == CONV);
    assign start    = (state == IDLE) && Enable && (period_cnt == '0);
    assign lead_err = (frame[FRAME_BITS-1 -: LEAD_ZEROS] != '0);

    adc_ad7476_sclk_gen #(
        .SCLK_DIV(SCLK_DIV)
    ) u_sclk_gen (
        .clk        (Clk),
        .rst        (Rst),
        .run        (run),
        .sclk       (ADC_SCLK),
        .rise_strobe(sclk_rise),
        .frame_done (frame_done)
    );

    // SDATA is timed by our own SCLK, so it is sampled without a synchronizer.
    always_ff @(posedge Clk) begin
        if (sclk_rise) begin
            frame <= {frame[FRAME_BITS-2:0], ADC_SDATA};
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state        <= IDLE;
            ADC_CSn      <= 1'b1;
            Fifo_Push    <= 1'b0;
            Fifo_Din     <= '0;
            Busy         <= 1'b0;
            Overrun      <= 1'b0;
            Frame_Err    <= 1'b0;
            Sample_Count <= '0;
            period_cnt   <= '0;
            quiet_cnt    <= '0;
        end else begin
            Fifo_Push <= 1'b0;

            if (start) begin
                period_cnt <= PERIOD_LOAD;
            end else if (!Enable) begin
                period_cnt <= '0;
            end else if (period_cnt != '0) begin
                period_cnt <= period_cnt - 1'b1;
            end

            if (quiet_cnt != QUIET_MAX) begin
                quiet_cnt <= quiet_cnt + 1'b1;
            end

            // Set events below are assigned later, so they win over a coincident clear.
            if (Err_Clr) begin
                Overrun   <= 1'b0;
                Frame_Err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= CONV;
                        ADC_CSn <= 1'b0;
                        Busy    <= 1'b1;
                    end
                end
                CONV: begin
                    if (frame_done) begin
                        ADC_CSn   <= 1'b1;
                        quiet_cnt <= QW'(1);
                        if (lead_err) begin
                            Frame_Err <= 1'b1;
                        end
                        if (Almost_Full) begin
                            Overrun <= 1'b1;
                            Busy    <= 1'b0;
                            state   <= QUIET;
                        end else begin
                            Fifo_Push <= 1'b1;
                            Fifo_Din  <= frame[7:0];
                            state     <= PUSH_LO;
                        end
                    end
                end
                PUSH_LO: begin
                    Fifo_Push    <= 1'b1;
                    Fifo_Din     <= {4'b0000, frame[DATA_BITS-1:8]};
                    Sample_Count <= Sample_Count + 1'b1;
                    state        <= PUSH_HI;
                end
                PUSH_HI: begin
                    Busy  <= 1'b0;
                    state <= QUIET;
                end
                QUIET: begin
                    if (quiet_cnt >= QUIET_EXIT) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_ad7476_capture.sv
// Directed bench for adc_ad7476_capture with a behavioural AD7476 serial model.
module tb_adc_ad7476_capture;

    localparam int SCLK_DIV = 2;
    localparam int PERIOD   = 200;
    localparam int QUIET    = 4;
    localparam int CNT_W    = 4;
    localparam int BUDGET   = 600;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             enable;
    logic             adc_sdata;
    logic             adc_sclk;
    logic             adc_csn;
    logic             almost_full;
    logic             fifo_push;
    logic [7:0]       fifo_din;
    logic             busy;
    logic             overrun;
    logic             frame_err;
    logic             err_clr;
    logic [CNT_W-1:0] sample_count;

    adc_ad7476_capture #(
        .SCLK_DIV     (SCLK_DIV),
        .SAMPLE_PERIOD(PERIOD),
        .CS_QUIET     (QUIET),
        .CNT_W        (CNT_W)
    ) dut (
        .Clk         (clk),
        .Rst         (rst),
        .Enable      (enable),
        .ADC_SDATA   (adc_sdata),
        .ADC_SCLK    (adc_sclk),
        .ADC_CSn     (adc_csn),
        .Almost_Full (almost_full),
        .Fifo_Push   (fifo_push),
        .Fifo_Din    (fifo_din),
        .Busy        (busy),
        .Overrun     (overrun),
        .Frame_Err   (frame_err),
        .Err_Clr     (err_clr),
        .Sample_Count(sample_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC model and monitor: new bit on every SCLK fall, log edges and pushes.
    logic [15:0] tx_word = 16'h0000;
    logic        csn_prev = 1'b1;
    logic        sclk_prev = 1'b1;
    int          fall_idx = 0;
    int          csn_rise_cyc = 0;
    int          fall_q[$];
    int          rise_q[$];
    logic [7:0]  push_q[$];

    always @(negedge clk) begin
        if (sclk_prev && !adc_sclk && !adc_csn) begin
            if (fall_idx < 16) adc_sdata = tx_word[15 - fall_idx];
            fall_idx++;
        end
        if (csn_prev && !adc_csn) begin
            fall_q.push_back(cyc);
            rise_q.delete();
            fall_idx = 0;
        end
        if (!csn_prev && adc_csn) csn_rise_cyc = cyc;
        if (adc_sclk && !sclk_prev && !adc_csn) rise_q.push_back(cyc);
        if (fifo_push) push_q.push_back(fifo_din);
        csn_prev  = adc_csn;
        sclk_prev = adc_sclk;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out after %0d cycles", name, BUDGET);
    endtask

    task automatic wait_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_fall(input int n0);
        for (int i = 0; i < BUDGET; i++) begin
            if (fall_q.size() > n0) return;
            wait_neg();
        end
        timeout("csn_fall");
    endtask

    task automatic wait_rises(input int n);
        for (int i = 0; i < BUDGET; i++) begin
            if (rise_q.size() >= n) return;
            wait_neg();
        end
        timeout("sclk_rises");
    endtask

    task automatic wait_csn_high();
        for (int i = 0; i < BUDGET; i++) begin
            if (adc_csn) return;
            wait_neg();
        end
        timeout("csn_rise");
    endtask

    task automatic run_frame(input logic [15:0] w, input logic af);
        int nf;
        push_q.delete();
        tx_word     = w;
        almost_full = af;
        nf          = fall_q.size();
        wait_fall(nf);
        wait_csn_high();
        repeat (4) wait_neg();
    endtask

    typedef struct {
        logic [15:0] word;
        logic        af;
        logic        exp_push;
        logic [7:0]  exp_lo;
        logic [7:0]  exp_hi;
        logic        exp_ovr;
        logic        exp_ferr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int         nf;
        int         t0;
        int         prev_rise;
        logic [7:0] exp_din;
        logic [CNT_W-1:0] exp_count;

        vecs[0] = '{16'h0ABC, 1'b0, 1'b1, 8'hBC, 8'h0A, 1'b0, 1'b0};
        vecs[1] = '{16'h0ABC, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{16'h0555, 1'b0, 1'b1, 8'h55, 8'h05, 1'b0, 1'b0};
        vecs[3] = '{16'hF123, 1'b0, 1'b1, 8'h23, 8'h01, 1'b0, 1'b1};
        vecs[4] = '{16'h0FFF, 1'b0, 1'b1, 8'hFF, 8'h0F, 1'b0, 1'b0};
        vecs[5] = '{16'h0000, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[6] = '{16'h8001, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1};

        enable      = 1'b0;
        almost_full = 1'b0;
        err_clr     = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_csn", adc_csn, 1);
        check("rst_sclk", adc_sclk, 1);
        check("rst_push", fifo_push, 0);
        check("rst_din", fifo_din, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_count", sample_count, 0);
        repeat (3) wait_neg();
        rst = 1'b0;
        enable = 1'b1;

        exp_din   = 8'h00;
        exp_count = '0;
        prev_rise = 0;
        for (int i = 0; i < 7; i++) begin
            push_q.delete();
            tx_word     = vecs[i].word;
            almost_full = vecs[i].af;
            nf          = fall_q.size();
            wait_fall(nf);
            t0 = (fall_q.size() > nf) ? fall_q[nf] : 0;
            wait_csn_high();
            repeat (4) wait_neg();

            check("n_sclk_rises", rise_q.size(), 16);
            for (int k = 0; k < rise_q.size(); k++)
                check("sclk_rise_time", rise_q[k] - t0, 4 * (k + 1));
            check("csn_low_len", csn_rise_cyc - t0, 65);
            if (i > 0) begin
                check("fall_spacing", fall_q[nf] - fall_q[nf-1], PERIOD);
                check("csn_high_gap", t0 - prev_rise, PERIOD - 65);
            end
            prev_rise = csn_rise_cyc;

            if (vecs[i].exp_push) begin
                exp_din   = vecs[i].exp_hi;
                exp_count = exp_count + 1'b1;
            end
            check("n_pushes", push_q.size(), vecs[i].exp_push ? 2 : 0);
            if (push_q.size() == 2) begin
                check("push_lo", push_q[0], vecs[i].exp_lo);
                check("push_hi", push_q[1], vecs[i].exp_hi);
            end
            check("overrun", overrun, vecs[i].exp_ovr);
            check("frame_err", frame_err, vecs[i].exp_ferr);
            check("count", sample_count, exp_count);
            check("din_hold", fifo_din, exp_din);
            check("busy_after", busy, 0);

            err_clr = 1'b1;
            wait_neg();
            err_clr = 1'b0;
            check("clr_overrun", overrun, 0);
            check("clr_frame_err", frame_err, 0);
        end

        // Err_Clr coincident with a new framing error: the set wins.
        push_q.delete();
        tx_word     = 16'h4000;
        almost_full = 1'b0;
        nf          = fall_q.size();
        wait_fall(nf);
        wait_rises(16);
        err_clr = 1'b1;
        wait_neg();
        err_clr = 1'b0;
        check("ferr_set_wins", frame_err, 1);
        wait_csn_high();
        repeat (4) wait_neg();
        exp_count = exp_count + 1'b1;
        check("count_ferr_frame", sample_count, exp_count);

        // Enable dropped mid-frame: current frame still pushes, none follows.
        push_q.delete();
        tx_word = 16'h0321;
        nf      = fall_q.size();
        wait_fall(nf);
        wait_rises(5);
        enable = 1'b0;
        wait_csn_high();
        repeat (4) wait_neg();
        check("en_drop_pushes", push_q.size(), 2);
        if (push_q.size() == 2) begin
            check("en_drop_lo", push_q[0], 8'h21);
            check("en_drop_hi", push_q[1], 8'h03);
        end
        nf = fall_q.size();
        repeat (450) wait_neg();
        check("en_drop_no_frame", fall_q.size(), nf);
        check("en_drop_csn", adc_csn, 1);

        // Reset asserted mid-frame.
        enable  = 1'b1;
        push_q.delete();
        tx_word = 16'h0777;
        nf      = fall_q.size();
        wait_fall(nf);
        wait_rises(8);
        rst = 1'b1;
        #1;
        check("midrst_csn", adc_csn, 1);
        check("midrst_sclk", adc_sclk, 1);
        wait_neg();
        wait_neg();
        check("midrst_no_push", push_q.size(), 0);
        check("midrst_count", sample_count, 0);
        check("midrst_busy", busy, 0);
        rst = 1'b0;
        run_frame(16'h0456, 1'b0);
        check("post_rst_pushes", push_q.size(), 2);
        if (push_q.size() == 2) begin
            check("post_rst_lo", push_q[0], 8'h56);
            check("post_rst_hi", push_q[1], 8'h04);
        end
        check("post_rst_count", sample_count, 1);

        // Sample_Count wraps after the 16th pushed sample.
        for (int i = 0; i < 14; i++) run_frame(16'h0A00 | 16'(i), 1'b0);
        check("count_15", sample_count, 15);
        run_frame(16'h0B7E, 1'b0);
        check("count_wrap", sample_count, 0);
        if (push_q.size() == 2) begin
            check("wrap_lo", push_q[0], 8'h7E);
            check("wrap_hi", push_q[1], 8'h0B);
        end else begin
            check("wrap_pushes", push_q.size(), 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
